// File: rtl/class_sched.sv
// Collects ten serial FC scores, holds them for the external argmax comparator and hands off the result.
// Optional: CLASS_FRAME_CNT_EN adds a 16-bit frame_cnt output counting result handshakes.
module class_sched #(
  parameter int DATA_W  = 16,
  parameter int N_CLASS = 10,
  parameter int CMP_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              score_valid,
  output logic              score_ready,
  input  logic [DATA_W-1:0] score_data,
  input  logic              score_last,
  output logic [DATA_W-1:0] class0,
  output logic [DATA_W-1:0] class1,
  output logic [DATA_W-1:0] class2,
  output logic [DATA_W-1:0] class3,
  output logic [DATA_W-1:0] class4,
  output logic [DATA_W-1:0] class5,
  output logic [DATA_W-1:0] class6,
  output logic [DATA_W-1:0] class7,
  output logic [DATA_W-1:0] class8,
  output logic [DATA_W-1:0] class9,
  input  logic [DATA_W-1:0] cmp_value,
  input  logic [3:0]        cmp_index,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_value,
  output logic [3:0]        res_index,
  output logic              busy,
  output logic              frame_err
`ifdef CLASS_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  // state  | meaning
  // S_IDLE | no frame; first accepted score goes to class0
  // S_LOAD | collecting scores 1..9
  // S_WAIT | class registers frozen, waiting out comparator latency
  // S_OUT  | result presented, waiting for res_ready
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_OUT} state_t;

  localparam int WCW = $clog2(CMP_LAT + 1);
  localparam logic [WCW-1:0] WAIT_END = WCW'(CMP_LAT);
  localparam logic [3:0] LAST_IDX = 4'(N_CLASS - 1);

  state_t state, state_nxt;

  logic [3:0]        load_cnt;
  logic [WCW-1:0]    wait_cnt;
  logic [DATA_W-1:0] class_q [N_CLASS];
  logic [DATA_W-1:0] res_value_q;
  logic [3:0]        res_index_q;
  logic              frame_err_q;

  logic accept;
  logic load_inc;
  logic load_clr;
  logic err_set;
  logic wait_clr;
  logic capture;
  logic handshake;

  assign score_ready = ((state == S_IDLE) || (state == S_LOAD)) && !rst;
  assign accept      = score_valid && score_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_inc  = 1'b0;
    load_clr  = 1'b0;
    err_set   = 1'b0;
    wait_clr  = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          if (load_cnt == LAST_IDX) begin
            // A missing last marker is flagged but the full frame is still evaluated.
            err_set   = !score_last;
            load_clr  = 1'b1;
            wait_clr  = 1'b1;
            state_nxt = S_WAIT;
          end else if (score_last) begin
            err_set   = 1'b1;
            load_clr  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            load_inc  = 1'b1;
            state_nxt = S_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_END) begin
          capture   = 1'b1;
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          handshake = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt    <= '0;
      wait_cnt    <= '0;
      res_value_q <= '0;
      res_index_q <= '0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < N_CLASS; i++) class_q[i] <= '0;
    end else begin
      frame_err_q <= err_set;
      if (accept) begin
        for (int i = 0; i < N_CLASS; i++)
          if (load_cnt == 4'(i)) class_q[i] <= score_data;
      end
      if (load_clr)      load_cnt <= '0;
      else if (load_inc) load_cnt <= load_cnt + 4'd1;
      if (wait_clr)               wait_cnt <= '0;
      else if (state == S_WAIT)   wait_cnt <= wait_cnt + 1'b1;
      if (capture) begin
        res_value_q <= cmp_value;
        res_index_q <= cmp_index;
      end
    end
  end

`ifdef CLASS_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            frame_cnt_q <= '0;
    else if (handshake) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt = frame_cnt_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

  assign class0    = class_q[0];
  assign class1    = class_q[1];
  assign class2    = class_q[2];
  assign class3    = class_q[3];
  assign class4    = class_q[4];
  assign class5    = class_q[5];
  assign class6    = class_q[6];
  assign class7    = class_q[7];
  assign class8    = class_q[8];
  assign class9    = class_q[9];
  assign res_valid = (state == S_OUT);
  assign res_value = res_value_q;
  assign res_index = res_index_q;
  assign busy      = (state != S_IDLE);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_class_sched.sv
// Directed bench for class_sched; includes a 4-stage argmax comparator model (ties to higher index).
module tb_class_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        score_valid;
  logic        score_ready;
  logic [15:0] score_data;
  logic        score_last;
  logic [15:0] class0, class1, class2, class3, class4, class5, class6, class7, class8, class9;
  logic [15:0] cmp_value;
  logic [3:0]  cmp_index;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_value;
  logic [3:0]  res_index;
  logic        busy;
  logic        frame_err;
`ifdef CLASS_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] sc [10];

  always #5 clk = ~clk;

  class_sched dut (
    .clk(clk), .rst(rst),
    .score_valid(score_valid), .score_ready(score_ready),
    .score_data(score_data), .score_last(score_last),
    .class0(class0), .class1(class1), .class2(class2), .class3(class3), .class4(class4),
    .class5(class5), .class6(class6), .class7(class7), .class8(class8), .class9(class9),
    .cmp_value(cmp_value), .cmp_index(cmp_index),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_value(res_value), .res_index(res_index),
    .busy(busy), .frame_err(frame_err)
`ifdef CLASS_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  // External comparator model: argmax, ties to higher index, CMP_LAT = 4 register stages.
  logic [15:0] cls [10];
  logic [15:0] am_v;
  logic [3:0]  am_i;
  logic [19:0] pipe [4];
  always_comb begin
    cls[0] = class0; cls[1] = class1; cls[2] = class2; cls[3] = class3; cls[4] = class4;
    cls[5] = class5; cls[6] = class6; cls[7] = class7; cls[8] = class8; cls[9] = class9;
  end
  always_comb begin
    am_v = cls[0];
    am_i = 4'd0;
    for (int i = 1; i < 10; i++)
      if (cls[i] >= am_v) begin
        am_v = cls[i];
        am_i = 4'(i);
      end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {am_i, am_v};
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign cmp_index = pipe[3][19:16];
  assign cmp_value = pipe[3][15:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives n scores from sc[], one per cycle; last asserted on index last_pos (-1 = never).
  task automatic send(input int n, input int last_pos);
    for (int i = 0; i < n; i++) begin
      score_valid = 1'b1;
      score_data  = sc[i];
      score_last  = (i == last_pos);
      @(posedge clk); #1;
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
    score_data  = '0;
  endtask

  task automatic wait_result(input string tag);
    int t = 0;
    while (!res_valid && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    chk(tag, {31'd0, res_valid}, 32'd1);
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; score_valid = 1'b0; score_data = '0; score_last = 1'b0; res_ready = 1'b0;
    #12;
    chk("rst_score_ready", {31'd0, score_ready}, 32'd0);
    chk("rst_outputs", {busy, frame_err, res_valid, res_index, res_value}, 32'd0);
    chk("rst_class", {class0, class9}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", {31'd0, score_ready}, 32'd1);

    // Basic frame with exact latency
    for (int i = 0; i < 10; i++) sc[i] = 16'(10 * (i + 1));
    send(10, 9);
    chk("basic_wait_state", {busy, score_ready, frame_err}, {29'd0, 3'b100});
    repeat (4) @(posedge clk);
    #1;
    chk("basic_not_early", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk("basic_latency", {31'd0, res_valid}, 32'd1);
    chk("basic_result", {res_index, res_value}, {12'd0, 4'd9, 16'd100});
    take_result();
    chk("basic_after_hs", {busy, res_valid, res_value}, {14'd0, 2'b00, 16'd100});

    // Ties resolve to higher index
    for (int i = 0; i < 10; i++) sc[i] = 16'h0100;
    send(10, 9);
    wait_result("tie_timeout");
    chk("tie_result", {res_index, res_value}, {12'd0, 4'd9, 16'h0100});
    take_result();
    for (int i = 0; i < 10; i++) sc[i] = 16'h0000;
    sc[3] = 16'hFFFF;
    send(10, 9);
    wait_result("max3_timeout");
    chk("max3_result", {res_index, res_value}, {12'd0, 4'd3, 16'hFFFF});
    take_result();

    // Backpressure: result and class registers held, scores ignored
    for (int i = 0; i < 10; i++) sc[i] = 16'(i);
    sc[5] = 16'h1234;
    send(10, 9);
    wait_result("bp_timeout");
    for (int k = 0; k < 20; k++) begin
      score_valid = k[0];
      score_data  = 16'hFFFF;
      score_last  = 1'b1;
      @(negedge clk);
      chk("bp_hold", {res_valid, score_ready, res_index, res_value},
          {10'd0, 1'b1, 1'b0, 4'd5, 16'h1234});
      chk("bp_class", {class5, class9}, {16'h1234, 16'd9});
      @(posedge clk); #1;
    end
    score_valid = 1'b0; score_last = 1'b0; score_data = '0;
    take_result();
    for (int i = 0; i < 10; i++) sc[i] = 16'(100 - 10 * i);
    send(10, 9);
    wait_result("bp_next_timeout");
    chk("bp_next_result", {res_index, res_value}, {12'd0, 4'd0, 16'd100});
    take_result();

    // Early last on 4th score
    for (int i = 0; i < 10; i++) sc[i] = 16'd1;
    sc[7] = 16'h0500;
    send(4, 3);
    chk("early_err", {busy, frame_err}, {30'd0, 2'b01});
    @(posedge clk); #1;
    chk("early_err_pulse", {31'd0, frame_err}, 32'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    chk("early_no_result", {31'd0, seen}, 32'd0);
    send(10, 9);
    wait_result("early_next_timeout");
    chk("early_next_result", {res_index, res_value}, {12'd0, 4'd7, 16'h0500});
    take_result();

    // Missing last: error flagged, frame still evaluated
    for (int i = 0; i < 10; i++) sc[i] = 16'd2;
    sc[2] = 16'h0900;
    send(10, -1);
    chk("nolast_err", {busy, frame_err}, {30'd0, 2'b11});
    @(posedge clk); #1;
    chk("nolast_err_pulse", {31'd0, frame_err}, 32'd0);
    wait_result("nolast_timeout");
    chk("nolast_result", {res_index, res_value}, {12'd0, 4'd2, 16'h0900});
    take_result();

    // Reset two cycles into WAIT
    for (int i = 0; i < 10; i++) sc[i] = 16'd3;
    sc[6] = 16'h0777;
    send(10, 9);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {busy, frame_err, res_valid, score_ready, res_index, res_value}, 32'd0);
    chk("midrst_class", {class0, class6}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (res_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {score_ready, seen}, {30'd0, 2'b10});
    for (int i = 0; i < 10; i++) sc[i] = 16'(50 + i);
    sc[1] = 16'hABCD;
    send(10, 9);
    wait_result("midrst_next_timeout");
    chk("midrst_next_result", {res_index, res_value}, {12'd0, 4'd1, 16'hABCD});
    take_result();

`ifdef CLASS_FRAME_CNT_EN
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("fcnt_reset", {16'd0, frame_cnt}, 32'd0);
    for (int f = 0; f < 3; f++) begin
      send(10, 9);
      wait_result("fcnt_timeout");
      take_result();
    end
    chk("fcnt_three", {16'd0, frame_cnt}, 32'd3);
    force dut.frame_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt_q;
    chk("fcnt_preload", {16'd0, frame_cnt}, 32'h0000FFFF);
    send(10, 9);
    wait_result("fcnt_wrap_timeout");
    take_result();
    chk("fcnt_wrap", {16'd0, frame_cnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/class_sched.md
# class_sched

Sequencing controller for the fully-connected output stage of the LeNet classifier. It collects the ten per-class FC scores arriving serially, holds them as stable parallel inputs for the 4-stage pipelined argmax comparator, and waits out the comparator latency. It then captures the winning index and value and presents them downstream on a valid/ready handshake. One frame (one image) is in flight at a time.

## Interface
- DATA_W, 16, score width; must match comparator input width
- N_CLASS, 10, scores per frame; fixed at 10 by the comparator
- CMP_LAT, 4, comparator pipeline depth in clocks
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- score_valid  input  1  score_data valid
- score_ready  output  1  controller accepts a score this cycle
- score_data  input  DATA_W  score for the next class index, unsigned
- score_last  input  1  marks the final score of a frame
- class0 … class9  output  DATA_W each  held scores to the comparator inputs
- cmp_value  input  DATA_W  comparator winning value
- cmp_index  input  4  comparator winning index
- res_valid  output  1  result available
- res_ready  input  1  downstream accepts the result
- res_value  output  DATA_W  captured winning score
- res_index  output  4  captured winning class, 0–9
- busy  output  1  high in any state other than IDLE
- frame_err  output  1  one-cycle pulse on a framing error

## Operation
- The FSM has four states: IDLE, LOAD, WAIT, OUT.
- **Accept rule:** a score is accepted when score_valid and score_ready are both high. score_ready = 1 in IDLE and LOAD only.
- **IDLE:** the first accept writes class0, sets load_cnt to 1 and moves to LOAD.
- **LOAD:** each accept writes class[load_cnt], then increments load_cnt (4 bits).
- **Normal frame end:** the accept at load_cnt == 9 with score_last = 1 goes to WAIT.
- **Missing last:** the accept at load_cnt == 9 with score_last = 0 pulses frame_err and still goes to WAIT. The frame is evaluated.
- **Early last:** score_last = 1 on an accept with load_cnt < 9 pulses frame_err, clears load_cnt and returns to IDLE. No result is produced. class registers keep their partially updated values.
- **WAIT:** class0–9 are frozen. wait_cnt clears on entry and increments each cycle. When wait_cnt == CMP_LAT, cmp_value and cmp_index are captured into res_value and res_index, and the FSM goes to OUT.
- **OUT:** res_valid = 1. The result and class registers are held unchanged until res_ready = 1. On that handshake the FSM goes to IDLE and res_valid drops the next cycle. res_value and res_index keep their last captured values.
- **Scores:** scores are unsigned. The comparator breaks ties toward the higher class index. The controller does no arithmetic on scores.
- **Reset:** all registers go to 0 and the state to IDLE, immediately. Any frame in progress is discarded, including a reset during WAIT or OUT.

## Timing
- **Reset values:** score_ready 0 while rst is asserted, then 1 in IDLE. res_valid 0; res_value 0; res_index 0; class0–9 0; busy 0; frame_err 0.
- **Latency:** the 10th accept is at edge E. The comparator output is valid after edge E+CMP_LAT. Capture happens at edge E+CMP_LAT+1, so res_valid is high from edge E+5 with the defaults.
- **Throughput:** a new frame can start the cycle after the result handshake. The minimum frame period is 10 + 5 + 1 = 16 cycles.
- **frame_err:** registered, high for exactly one cycle after the offending accept.
- **Stability:** res_valid, res_value and res_index must not change while res_valid = 1 and res_ready = 0.

## Configuration
- **CLASS_FRAME_CNT_EN defined:** adds output port frame_cnt, 16 bits.
  - Reset value 0.
  - Increments on each result handshake.
  - Wraps from 0xFFFF to 0x0000.
- **Not defined:** the port and its counter are absent. All other behaviour is identical.

## Test plan
- **Basic frame:** scores 10, 20, …, 100 for classes 0–9, back-to-back, last on the 10th. Required: res_index = 9, res_value = 100, res_valid rises exactly 5 cycles after the 10th accept.
- **Ties:** all ten scores 0x0100. Required: res_index = 9, res_value = 0x0100. Then scores with class 3 = 0xFFFF and the rest 0. Required: res_index = 3.
- **Backpressure:** hold res_ready = 0 for 20 cycles in OUT. Required: res_valid stays high and the result is unchanged, score_ready = 0 throughout, and score_valid pulses are ignored. Release res_ready; a following frame then produces the correct result.
- **Framing errors:**
  - score_last on the 4th score. Required: one frame_err pulse, no res_valid, FSM back in IDLE. The next full frame evaluates correctly.
  - 10 scores with no last. Required: frame_err pulse and the result is still produced.
- **Reset mid-operation:** assert rst two cycles into WAIT. Required: all outputs are 0 immediately and no res_valid appears after release. A subsequent frame is correct.
- **Frame counter (CLASS_FRAME_CNT_EN only):** three completed frames. Required: frame_cnt = 3. Preload the counter to 0xFFFF by forcing it, complete one frame. Required: frame_cnt = 0.
